// File: rtl/serial_sub16_pkg.sv
// sub_pkg: shared widths and FSM state type for the serial 16-bit subtractor.
package sub_pkg;
    localparam int DATA_W     = 16;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 4;
    localparam int K_W        = $clog2(NUM_SLICES);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/serial_sub16_if.sv
// serial_sub16_if: operand/result valid-ready bus for serial_sub16.
interface serial_sub16_if;
    import sub_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              bin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] D;
    logic              bout;
    logic              ovf;
    modport slave  (input in_valid, A, B, bin, out_ready,
                    output in_ready, out_valid, D, bout, ovf);
    modport master (output in_valid, A, B, bin, out_ready,
                    input in_ready, out_valid, D, bout, ovf);
endinterface

// File: rtl/serial_sub16_sub4.sv
// sub_4: 4-bit subtract-with-borrow slice, reused across all slices.
module sub_4
    import sub_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);
    // The extra top bit goes to 1 exactly when the slice result is negative.
    assign {bout, d} = {1'b0, x} - {1'b0, y} - {{SLICE_W{1'b0}}, bin};
endmodule

// File: rtl/serial_sub16.sv
// serial_sub16: 16-bit subtractor computing one 4-bit slice per clock.
module serial_sub16
    import sub_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    serial_sub16_if.slave  bus
);
    localparam int MSB = DATA_W - 1;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic              borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [SLICE_W-1:0] s_d;
    logic              s_b;

    sub_4 u_sub (
        .x    (a_q[k_q*SLICE_W +: SLICE_W]),
        .y    (b_q[k_q*SLICE_W +: SLICE_W]),
        .bin  (borrow_q),
        .d    (s_d),
        .bout (s_b)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        if (state_q == IDLE) begin
            in_ready_d = 1'b1;
            // in_ready stays low for the first cycle after reset, so gate on it too.
            if (bus.in_valid && in_ready_q) begin
                a_d        = bus.A;
                b_d        = bus.B;
                borrow_d   = bus.bin;
                k_d        = '0;
                state_d    = BUSY;
                in_ready_d = 1'b0;
            end
        end else if (state_q == BUSY) begin
            d_d[k_q*SLICE_W +: SLICE_W] = s_d;
            borrow_d = s_b;
            k_d      = k_q + K_W'(1);
            if (k_q == K_W'(NUM_SLICES - 1)) begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                bout_d      = s_b;
                ovf_d       = (a_q[MSB] ^ b_q[MSB]) & (s_d[SLICE_W-1] ^ a_q[MSB]);
            end
        end else if (bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16: scoreboard bench for serial_sub16 (directed, stall, abort, streaming).
module tb_serial_sub16;
    import sub_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sub16_if bus();
    serial_sub16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [17:0] sb[$];

    logic [15:0] va[5] = '{16'h1234, 16'h0000, 16'h0010, 16'h8000, 16'h7FFF};
    logic [15:0] vb[5] = '{16'h0234, 16'h0001, 16'h000F, 16'h0001, 16'hFFFF};
    logic        vi[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] vd[5] = '{16'h1000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
    logic        vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        vov[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reference: full-width subtraction, independent of the slice structure.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] diff;
        diff = {1'b0, a} - {1'b0, b} - {16'b0, bi};
        return {(a[15] ^ b[15]) & (diff[15] ^ a[15]), diff[16], diff[15:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.bin = bi;
        tick();
        bus.in_valid = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        bus.bin = ~bi;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.bin = 1'b0;
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.D !== 16'h0000) begin bad++; $display("FAIL rst_D got=%h exp=0000", bus.D); end
        total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL rst_bout got=%b exp=0", bus.bout); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        rst_n = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_vectors;
        int lat;
        logic [17:0] exp;
        for (int i = 0; i < 5; i++) begin
            sb.push_back({vov[i], vbo[i], vd[i]});
            start_op(va[i], vb[i], vi[i]);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_early_valid got=%b exp=0", i, bus.out_valid); end
            wait_done(lat);
            total++; if (lat != 4) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=4", i, lat); end
            exp = sb.pop_front();
            total++; if (bus.D !== exp[15:0]) begin bad++; $display("FAIL vec%0d_D got=%h exp=%h", i, bus.D, exp[15:0]); end
            total++; if (bus.bout !== exp[16]) begin bad++; $display("FAIL vec%0d_bout got=%b exp=%b", i, bus.bout, exp[16]); end
            total++; if (bus.ovf !== exp[17]) begin bad++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, bus.ovf, exp[17]); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_valid_drop got=%b exp=0", i, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_in_ready got=%b exp=1", i, bus.in_ready); end
        end
    endtask

    task automatic test_stall;
        int lat;
        logic [17:0] exp;
        sb.push_back(model(16'h1234, 16'h0234, 1'b0));
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL stall_latency got=%0d exp=4", lat); end
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.A = 16'($urandom);
            bus.B = 16'($urandom);
            bus.bin = 1'($urandom);
            tick();
            total++; if ({bus.ovf, bus.bout, bus.D} !== exp) begin bad++; $display("FAIL stall%0d_result got=%h exp=%h", i, {bus.ovf, bus.bout, bus.D}, exp); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall%0d_in_ready got=%b exp=0", i, bus.in_ready); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall%0d_out_valid got=%b exp=1", i, bus.out_valid); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_in_ready got=%b exp=1", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_idle%0d_valid got=%b exp=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_abort;
        int lat;
        logic [17:0] exp;
        start_op(16'h5555, 16'h1111, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if ({bus.out_valid, bus.ovf, bus.bout, bus.D} !== 19'h0) begin bad++; $display("FAIL abort_outputs got=%h exp=0", {bus.out_valid, bus.ovf, bus.bout, bus.D}); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready_rst got=%b exp=0", bus.in_ready); end
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
        for (int i = 0; i < 8; i++) begin
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_idle%0d_valid got=%b exp=0", i, bus.out_valid); end
            if (i < 7) tick();
        end
        sb.push_back({1'b0, 1'b1, 16'hFFFF});
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
        exp = sb.pop_front();
        total++; if (bus.D !== exp[15:0]) begin bad++; $display("FAIL abort_next_D got=%h exp=%h", bus.D, exp[15:0]); end
        total++; if (bus.bout !== exp[16]) begin bad++; $display("FAIL abort_next_bout got=%b exp=%b", bus.bout, exp[16]); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        localparam int N = 24;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [17:0] exp;
        bus.out_ready = 1'b1;
        while (got < N && cyc < 400) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++; $display("FAIL b2b_extra_result got=%h exp=none", {bus.ovf, bus.bout, bus.D});
                end else begin
                    exp = sb.pop_front();
                    total++; if ({bus.ovf, bus.bout, bus.D} !== exp) begin bad++; $display("FAIL b2b%0d_result got=%h exp=%h", got, {bus.ovf, bus.bout, bus.D}, exp); end
                end
                got++;
            end
            bus.A = 16'($urandom);
            bus.B = (cyc % 5 == 0) ? bus.A : 16'($urandom);
            bus.bin = 1'($urandom);
            bus.in_valid = (sent < N);
            if (bus.in_ready && sent < N) begin
                sb.push_back(model(bus.A, bus.B, bus.bin));
                sent++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (got != N) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got, N); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from package constants DATA_W=16, SLICE_W=4, NUM_SLICES=4.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand set A/B/bin is valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  16  minuend, unsigned / two's complement.
REQ-007 B  input  16  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result D/bout/ovf is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 D  output  16  difference, A - B - bin mod 2^16.
REQ-012 bout  output  1  borrow-out: 1 iff A < B + bin, unsigned.
REQ-013 ovf  output  1  signed overflow: operand signs differ and D sign differs from A sign.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in BUSY and DONE, in_ready SHALL be 0.
REQ-016 Acceptance SHALL occur on an edge where state==IDLE and in_valid=1; A, B and bin are latched, the slice counter k=0 and state goes to BUSY.
REQ-017 In BUSY, each edge SHALL process one 4-bit slice k: D[4k+3:4k] = A_k - B_k - borrow; the borrow register takes that slice's borrow-out; k increments.
REQ-018 The borrow register SHALL be loaded with bin at acceptance.
REQ-019 After slice k=3, state SHALL go to DONE with bout = final borrow and ovf computed from A[15], B[15] and D[15].
REQ-020 Latency SHALL be exactly 4 edges from acceptance to out_valid=1, with no variation.
REQ-021 In DONE, out_valid SHALL be 1 and D/bout/ovf SHALL be held stable until an edge with out_ready=1.
REQ-022 That edge SHALL return state to IDLE; in_ready rises the next cycle; the block does not accept in the same cycle as the result handoff.
REQ-023 In_valid SHALL be ignored outside IDLE, and A/B/bin changes after acceptance SHALL NOT affect the result.
REQ-024 Outside DONE, out_valid SHALL be 0; D, bout and ovf hold their last values and are don't-care to the consumer.
REQ-025 Wrap-around SHALL be modulo 2^16 with no saturation; 0x0000-0x0001 yields 0xFFFF, bout=1.
REQ-026 The slice counter SHALL be 2 bits, wrap from 3 to 0 only on the transition BUSY->DONE, and never be used outside BUSY.

Reset
REQ-027 With rst_n=0 at an edge: state=IDLE, k=0, borrow=0, D=0x0000, bout=0, ovf=0, out_valid=0; in_ready=1 after the first edge with rst_n=1 (0 during reset).
REQ-028 Reset mid-BUSY or mid-DONE SHALL abort the operation with no result delivered; reset SHALL take priority over all handshakes.

Structure
REQ-029 A shared package sub_pkg SHALL hold DATA_W, SLICE_W, NUM_SLICES and the state enum typedef (IDLE, BUSY, DONE).
REQ-030 A combinational sub-module sub_4 SHALL compute the 4-bit slice: inputs x[3:0], y[3:0], bin; outputs d[3:0], bout. It SHALL be instantiated once and time-multiplexed over the slices.
REQ-031 Slice selection SHALL use indexed part-selects on k; there SHALL be no arithmetic wider than 5 bits in the datapath.

Verification
REQ-032 A=0x1234, B=0x0234, bin=0 -> D=0x1000, bout=0, ovf=0, out_valid exactly 4 edges after acceptance.
REQ-033 A=0x0000, B=0x0001, bin=0 -> D=0xFFFF, bout=1, ovf=0; A=0x0010, B=0x000F, bin=1 -> D=0x0000, bout=0 (borrow ripple across slices).
REQ-034 A=0x8000, B=0x0001 -> D=0x7FFF, ovf=1, bout=0; A=0x7FFF, B=0xFFFF -> D=0x8000, ovf=1, bout=1.
REQ-035 out_ready held 0 for 10 cycles in DONE, with A/B toggled and in_valid=1 -> D/bout/ovf stable, in_ready=0, no new acceptance; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 rst_n=0 for one edge after 2 BUSY edges -> out_valid never asserts for that operation, outputs all 0, in_ready=1 after release; the next operation A=0xFFFF, B=0xFFFF, bin=1 -> D=0xFFFF, bout=1.
REQ-037 A randomized back-to-back stream (in_valid held at 1, out_ready held at 1) SHALL match a reference model on every result, with exactly one result per acceptance.
